monte_move_scheduler: RTL and testbench

Sequencing controller for the four Monte Carlo statistics engines (one per restricted first move, directions 0–3) behind the UART bus bridge. On a start request it:
- resets the engines;
- lets them run for a programmable cycle budget;
- freezes a snapshot of their counters;
- picks the direction with the highest average move count per trial.

The chosen direction goes to the bus register file as `best_dir`, with a `done` pulse.

---
 rtl/monte_sched_pkg.sv | 18 +
 rtl/monte_move_scheduler_if.sv | 25 ++
 rtl/monte_score_cmp.sv | 39 +++
 rtl/monte_move_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_monte_move_scheduler.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/monte_sched_pkg.sv
// Shared types and widths for the Monte Carlo move scheduler.
package monte_sched_pkg;

    localparam int unsigned N_ENG   = 4;
    localparam int unsigned MAXMV_W = 16;
    localparam int unsigned TOTMV_W = 32;
    localparam int unsigned TRIAL_W = 32;

    typedef enum logic [2:0] {
        StIdle,
        StHold,
        StRun,
        StSnap,
        StCmp,
        StDone
    } state_e;

endpackage

// File: rtl/monte_move_scheduler_if.sv
// Bus-side handshake between the register file and the move scheduler.
interface monte_move_scheduler_if #(
    parameter int unsigned BUDGET_W = 24
) ();

    logic                start;
    logic                abort;
    logic [7:0]          seed_in;
    logic [BUDGET_W-1:0] budget;
    logic                busy;
    logic                done;
    logic [1:0]          best_dir;
    logic                no_result;

    modport master (
        output start, abort, seed_in, budget,
        input  busy, done, best_dir, no_result
    );

    modport slave (
        input  start, abort, seed_in, budget,
        output busy, done, best_dir, no_result
    );

endinterface

// File: rtl/monte_score_cmp.sv
// Cross-multiplied average comparator: a beats b iff tm_a/tt_a > tm_b/tt_b.
// MONTE_MAXMOVE_TIEBREAK_EN folds the max-move count into the tie decision.
module monte_score_cmp
    import monte_sched_pkg::*;
(
    input  logic [TOTMV_W-1:0] tm_a,
    input  logic [TRIAL_W-1:0] tt_a,
    input  logic [MAXMV_W-1:0] mx_a,
    input  logic [TOTMV_W-1:0] tm_b,
    input  logic [TRIAL_W-1:0] tt_b,
    input  logic [MAXMV_W-1:0] mx_b,
    output logic               a_better,
    output logic               tie
);

    localparam int unsigned PROD_W = TOTMV_W + TRIAL_W;

    logic [PROD_W-1:0] prod_a;
    logic [PROD_W-1:0] prod_b;

    assign prod_a = PROD_W'(tm_a) * PROD_W'(tt_b);
    assign prod_b = PROD_W'(tm_b) * PROD_W'(tt_a);

`ifdef MONTE_MAXMOVE_TIEBREAK_EN
    always_comb begin
        a_better = (prod_a > prod_b) || ((prod_a == prod_b) && (mx_a > mx_b));
        tie      = (prod_a == prod_b) && (mx_a == mx_b);
    end
`else
    logic unused_mx;
    assign unused_mx = ^{mx_a, mx_b};

    always_comb begin
        a_better = prod_a > prod_b;
        tie      = prod_a == prod_b;
    end
`endif

endmodule

// File: rtl/monte_move_scheduler.sv
// Runs the four direction engines for a budget, snapshots them and picks the best average.
// MONTE_MAXMOVE_TIEBREAK_EN enables the max-move-count tie-break and its snapshot registers.
module monte_move_scheduler
    import monte_sched_pkg::*;
#(
    parameter int unsigned RST_HOLD = 4,
    parameter int unsigned BUDGET_W = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    monte_move_scheduler_if.slave      bus,
    output logic                       monte_rst,
    output logic [7:0]                 seed,
    input  logic [N_ENG*MAXMV_W-1:0]   max_move_count,
    input  logic [N_ENG*TOTMV_W-1:0]   total_move_count,
    input  logic [N_ENG*TRIAL_W-1:0]   total_trial_count
);

    localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);

    state_e              state_q;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic [BUDGET_W-1:0] run_cnt_q;
    logic [1:0]          idx_q;
    logic [1:0]          best_idx_q;
    logic                best_valid_q;
    logic                monte_rst_q;
    logic [7:0]          seed_q;
    logic                busy_q;
    logic                done_q;
    logic [1:0]          best_dir_q;
    logic                no_result_q;

    logic [TOTMV_W-1:0]  tm_q [N_ENG];
    logic [TRIAL_W-1:0]  tt_q [N_ENG];

    logic [MAXMV_W-1:0]  mx_cur;
    logic [MAXMV_W-1:0]  mx_best;
    logic                cand_better;
    logic                unused_tie;
    logic                cand_elig;
    logic                cand_take;
    logic [7:0]          seed_eff;
    logic [BUDGET_W-1:0] budget_eff;

`ifdef MONTE_MAXMOVE_TIEBREAK_EN
    logic [MAXMV_W-1:0]  mx_q [N_ENG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(N_ENG); k++) mx_q[k] <= '0;
        end else if (state_q == StSnap && !bus.abort) begin
            for (int k = 0; k < int'(N_ENG); k++) begin
                mx_q[k] <= max_move_count[k*MAXMV_W +: MAXMV_W];
            end
        end
    end

    assign mx_cur  = mx_q[idx_q];
    assign mx_best = mx_q[best_idx_q];
`else
    logic unused_max;
    assign unused_max = ^max_move_count;
    assign mx_cur     = '0;
    assign mx_best    = '0;
`endif

    monte_score_cmp u_cmp (
        .tm_a     (tm_q[idx_q]),
        .tt_a     (tt_q[idx_q]),
        .mx_a     (mx_cur),
        .tm_b     (tm_q[best_idx_q]),
        .tt_b     (tt_q[best_idx_q]),
        .mx_b     (mx_best),
        .a_better (cand_better),
        .tie      (unused_tie)
    );

    // Engines are visited in ascending order, so keeping the incumbent on a tie favours
    // the lower index.
    always_comb begin
        cand_elig  = tt_q[idx_q] != '0;
        cand_take  = cand_elig && (!best_valid_q || cand_better);
        seed_eff   = (bus.seed_in == 8'h00) ? 8'h01 : bus.seed_in;
        budget_eff = (bus.budget == '0) ? BUDGET_W'(1) : bus.budget;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            hold_cnt_q   <= '0;
            run_cnt_q    <= '0;
            idx_q        <= '0;
            best_idx_q   <= '0;
            best_valid_q <= 1'b0;
            monte_rst_q  <= 1'b1;
            seed_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            best_dir_q   <= '0;
            no_result_q  <= 1'b0;
            for (int k = 0; k < int'(N_ENG); k++) begin
                tm_q[k] <= '0;
                tt_q[k] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (state_q != StIdle && bus.abort) begin
                state_q     <= StIdle;
                monte_rst_q <= 1'b1;
                busy_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        monte_rst_q <= 1'b1;
                        if (bus.start) begin
                            seed_q     <= seed_eff;
                            run_cnt_q  <= budget_eff;
                            hold_cnt_q <= HOLD_W'(RST_HOLD);
                            busy_q     <= 1'b1;
                            state_q    <= StHold;
                        end
                    end
                    StHold: begin
                        if (hold_cnt_q == HOLD_W'(1)) begin
                            monte_rst_q <= 1'b0;
                            state_q     <= StRun;
                        end else begin
                            hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
                        end
                    end
                    StRun: begin
                        if (run_cnt_q == BUDGET_W'(1)) begin
                            monte_rst_q <= 1'b1;
                            state_q     <= StSnap;
                        end else begin
                            run_cnt_q <= run_cnt_q - BUDGET_W'(1);
                        end
                    end
                    StSnap: begin
                        for (int k = 0; k < int'(N_ENG); k++) begin
                            tm_q[k] <= total_move_count[k*TOTMV_W +: TOTMV_W];
                            tt_q[k] <= total_trial_count[k*TRIAL_W +: TRIAL_W];
                        end
                        idx_q        <= '0;
                        best_idx_q   <= '0;
                        best_valid_q <= 1'b0;
                        state_q      <= StCmp;
                    end
                    StCmp: begin
                        if (cand_take) begin
                            best_idx_q   <= idx_q;
                            best_valid_q <= 1'b1;
                        end
                        if (idx_q == 2'd3) begin
                            // best_idx_q stays 0 while no engine is eligible
                            best_dir_q  <= cand_take ? idx_q : best_idx_q;
                            no_result_q <= !(best_valid_q || cand_elig);
                            done_q      <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                    StDone: begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign monte_rst     = monte_rst_q;
    assign seed          = seed_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.best_dir  = best_dir_q;
    assign bus.no_result = no_result_q;

endmodule

// File: tb/tb_monte_move_scheduler.sv
// Directed bench for monte_move_scheduler: timing, selection, tie, abort, budget/seed edges, reset.
module tb_monte_move_scheduler;

    localparam int unsigned H  = 4;
    localparam int unsigned BW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          monte_rst;
    logic [7:0]    seed;
    logic [63:0]   mx;
    logic [127:0]  tm;
    logic [127:0]  tt;

    int tests = 0;
    int fails = 0;

    int done_cyc, done_cnt, low_first, low_last, low_cnt, busy_first, busy_last, seed_chg;
    bit timed_out;
    logic [1:0] tie_exp;

    monte_move_scheduler_if #(.BUDGET_W(BW)) bus ();

    monte_move_scheduler #(.RST_HOLD(H), .BUDGET_W(BW)) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus),
        .monte_rst         (monte_rst),
        .seed              (seed),
        .max_move_count    (mx),
        .total_move_count  (tm),
        .total_trial_count (tt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1);
    end

    function automatic logic [127:0] p32(input logic [31:0] a0, input logic [31:0] a1,
                                         input logic [31:0] a2, input logic [31:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [63:0] p16(input logic [15:0] a0, input logic [15:0] a1,
                                        input logic [15:0] a2, input logic [15:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Start a run (current cycle becomes cycle 0) and observe it until busy drops.
    task automatic run(input logic [7:0] sv, input logic [BW-1:0] bv, input int pulse_at);
        logic [7:0] s0;
        done_cyc = -1; done_cnt = 0; low_first = -1; low_last = -1; low_cnt = 0;
        busy_first = -1; busy_last = -1; seed_chg = 0; timed_out = 1'b1;
        bus.seed_in = sv;
        bus.budget  = bv;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        s0 = seed;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (cyc == pulse_at) begin
                bus.start   = 1'b1;
                bus.seed_in = 8'hEE;
            end else begin
                bus.start = 1'b0;
            end
            if (!monte_rst) begin
                if (low_first < 0) low_first = cyc;
                low_last = cyc;
                low_cnt++;
            end
            if (bus.done) begin
                done_cyc = cyc;
                done_cnt++;
            end
            if (bus.busy) begin
                if (busy_first < 0) busy_first = cyc;
                busy_last = cyc;
            end
            if (seed !== s0) seed_chg++;
            if (!bus.busy) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int dcnt;
`ifdef MONTE_MAXMOVE_TIEBREAK_EN
        tie_exp = 2'd3;
`else
        tie_exp = 2'd1;
`endif
        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.seed_in = '0; bus.budget = '0;
        tm = '0; tt = '0; mx = '0;
        #2;
        check("rst_monte_rst", 64'(monte_rst), 64'(1));
        check("rst_seed", 64'(seed), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_best_dir", 64'(bus.best_dir), 64'(0));
        check("rst_no_result", 64'(bus.no_result), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic run: engine 1 has the best average (30)
        tm = p32(32'd100, 32'd300, 32'd250, 32'd0);
        tt = p32(32'd10, 32'd10, 32'd10, 32'd0);
        mx = p16(16'd1, 16'd2, 16'd3, 16'd4);
        run(8'h5A, 24'd20, -1);
        check("t1_timeout", 64'(timed_out), 64'(0));
        check("t1_done_cyc", 64'(done_cyc), 64'(30));
        check("t1_done_cnt", 64'(done_cnt), 64'(1));
        check("t1_low_first", 64'(low_first), 64'(5));
        check("t1_low_last", 64'(low_last), 64'(24));
        check("t1_low_cnt", 64'(low_cnt), 64'(20));
        check("t1_busy_first", 64'(busy_first), 64'(1));
        check("t1_busy_last", 64'(busy_last), 64'(30));
        check("t1_best_dir", 64'(bus.best_dir), 64'(1));
        check("t1_no_result", 64'(bus.no_result), 64'(0));
        check("t1_seed", 64'(seed), 64'(8'h5A));
        check("t1_seed_chg", 64'(seed_chg), 64'(0));

        // No engine completed a trial
        tm = p32(32'd5, 32'd6, 32'd7, 32'd8);
        tt = '0;
        run(8'h07, 24'd3, -1);
        check("t2_done_cyc", 64'(done_cyc), 64'(13));
        check("t2_done_cnt", 64'(done_cnt), 64'(1));
        check("t2_low_cnt", 64'(low_cnt), 64'(3));
        check("t2_best_dir", 64'(bus.best_dir), 64'(0));
        check("t2_no_result", 64'(bus.no_result), 64'(1));

        // Tie between engines 1 and 3 (average 10); engine 2 is worse, engine 0 ineligible
        tm = p32(32'd0, 32'd200, 32'd50, 32'd100);
        tt = p32(32'd0, 32'd20, 32'd10, 32'd10);
        mx = p16(16'd99, 16'd40, 16'd70, 16'd55);
        run(8'h03, 24'd2, -1);
        check("t3_done_cyc", 64'(done_cyc), 64'(12));
        check("t3_best_dir", 64'(bus.best_dir), 64'(tie_exp));
        check("t3_no_result", 64'(bus.no_result), 64'(0));

        // Abort during RUN at cycle 10
        tm = p32(32'd100, 32'd300, 32'd250, 32'd0);
        tt = p32(32'd10, 32'd10, 32'd10, 32'd0);
        bus.seed_in = 8'h09; bus.budget = 24'd20; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("t4_pre_monte_rst", 64'(monte_rst), 64'(0));
        check("t4_pre_busy", 64'(bus.busy), 64'(1));
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("t4_busy", 64'(bus.busy), 64'(0));
        check("t4_monte_rst", 64'(monte_rst), 64'(1));
        check("t4_done", 64'(bus.done), 64'(0));
        check("t4_best_dir", 64'(bus.best_dir), 64'(tie_exp));
        check("t4_no_result", 64'(bus.no_result), 64'(0));
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done || bus.busy) dcnt++;
            @(negedge clk);
        end
        check("t4_no_done_after", 64'(dcnt), 64'(0));

        // Zero seed and zero budget
        run(8'h00, 24'd0, -1);
        check("t5_seed", 64'(seed), 64'(8'h01));
        check("t5_low_cnt", 64'(low_cnt), 64'(1));
        check("t5_low_first", 64'(low_first), 64'(5));
        check("t5_done_cyc", 64'(done_cyc), 64'(11));
        check("t5_best_dir", 64'(bus.best_dir), 64'(1));

        // start while busy is ignored
        run(8'h33, 24'd5, 7);
        check("t6_done_cyc", 64'(done_cyc), 64'(15));
        check("t6_done_cnt", 64'(done_cnt), 64'(1));
        check("t6_seed", 64'(seed), 64'(8'h33));
        check("t6_seed_chg", 64'(seed_chg), 64'(0));
        check("t6_busy_last", 64'(busy_last), 64'(15));
        @(negedge clk);
        check("t6_stays_idle", 64'(bus.busy), 64'(0));

        // Asynchronous reset in the middle of CMP (cycle 9)
        bus.seed_in = 8'h44; bus.budget = 24'd2; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        check("t7_pre_busy", 64'(bus.busy), 64'(1));
        #1 rst = 1'b1;
        #1;
        check("t7_monte_rst", 64'(monte_rst), 64'(1));
        check("t7_seed", 64'(seed), 64'(0));
        check("t7_busy", 64'(bus.busy), 64'(0));
        check("t7_done", 64'(bus.done), 64'(0));
        check("t7_best_dir", 64'(bus.best_dir), 64'(0));
        check("t7_no_result", 64'(bus.no_result), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t7_idle_after", 64'(bus.busy), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
